// File: rtl/mcl_test_node_array.sv
// Array of independent MCL endpoint test nodes: loopback FIFO, counter
// generator, sequence checker or sink per channel, with status counters.
module mcl_test_node_array #(
    parameter int num_ch_p = 10,
    parameter int data_width_p = 80,
    parameter int fifo_els_p = 4,
    parameter logic [data_width_p-1:0] mask_p = {data_width_p{1'b1}},
    parameter int cnt_width_p = 32
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_ch_p-1:0]              en_i,
    input  logic [2*num_ch_p-1:0]            mode_i,
    input  logic [num_ch_p-1:0]              v_i,
    input  logic [data_width_p*num_ch_p-1:0] data_i,
    output logic [num_ch_p-1:0]              ready_o,
    output logic [num_ch_p-1:0]              v_o,
    output logic [data_width_p*num_ch_p-1:0] data_o,
    input  logic [num_ch_p-1:0]              yumi_i,
    output logic [cnt_width_p*num_ch_p-1:0]  rx_count_o,
    output logic [num_ch_p-1:0]              err_o
);

    localparam int PW = $clog2(fifo_els_p);

    typedef enum logic [1:0] {
        M_LOOP = 2'b00,
        M_GEN  = 2'b01,
        M_CHK  = 2'b10,
        M_SNK  = 2'b11
    } mode_e;

    for (genvar i = 0; i < num_ch_p; i++) begin : g_ch
        mode_e                   mode_q, mode_d, mode_in;
        logic [PW:0]             wp_q, wp_d, rp_q, rp_d;
        logic [data_width_p-1:0] gen_q, gen_d, exp_q, exp_d;
        logic [cnt_width_p-1:0]  cnt_q, cnt_d;
        logic                    err_q, err_d;
        logic [data_width_p-1:0] mem_q [fifo_els_p];
        logic [data_width_p-1:0] din, dat;
        logic flush, act, empty, full, rdy, vld, acc, deq, enq;

        assign mode_in = mode_e'(mode_i[2*i +: 2]);
        assign din     = data_i[i*data_width_p +: data_width_p];
        assign flush   = (mode_in != mode_q);
        // Outputs are held quiet while reset is asserted or a flush is in progress
        assign act     = en_i[i] & ~flush & ~reset_i;
        assign empty   = (wp_q == rp_q);
        assign full    = (wp_q[PW] != rp_q[PW]) &&
                         (wp_q[PW-1:0] == rp_q[PW-1:0]);

        always_comb begin
            rdy = 1'b0;
            vld = 1'b0;
            dat = '0;
            if (act) begin
                unique case (mode_q)
                    M_LOOP: begin
                        rdy = ~full;
                        vld = ~empty;
                        dat = mem_q[rp_q[PW-1:0]];
                    end
                    M_GEN: begin
                        rdy = 1'b1;
                        vld = 1'b1;
                        dat = gen_q;
                    end
                    M_CHK, M_SNK: rdy = 1'b1;
                endcase
            end
            if (!vld) dat = '0;
        end

        assign acc = v_i[i] & rdy;
        assign deq = vld & yumi_i[i];
        assign enq = acc & (mode_q == M_LOOP);

        always_comb begin
            mode_d = mode_q;
            wp_d   = wp_q;
            rp_d   = rp_q;
            gen_d  = gen_q;
            exp_d  = exp_q;
            cnt_d  = cnt_q;
            err_d  = err_q;
            if (flush) begin
                mode_d = mode_in;
                wp_d   = '0;
                rp_d   = '0;
                gen_d  = '0;
                exp_d  = '0;
                cnt_d  = '0;
                err_d  = 1'b0;
            end else begin
                if (acc) cnt_d = cnt_q + 1'b1;
                if (enq) wp_d = wp_q + 1'b1;
                if (deq && mode_q == M_LOOP) rp_d = rp_q + 1'b1;
                if (deq && mode_q == M_GEN) gen_d = gen_q + 1'b1;
                if (acc && mode_q == M_CHK) begin
                    exp_d = exp_q + 1'b1;
                    if (din != exp_q) err_d = 1'b1;
                end
            end
        end

        always_ff @(posedge clk_i or posedge reset_i) begin
            if (reset_i) begin
                mode_q <= M_LOOP;
                wp_q   <= '0;
                rp_q   <= '0;
                gen_q  <= '0;
                exp_q  <= '0;
                cnt_q  <= '0;
                err_q  <= 1'b0;
            end else begin
                mode_q <= mode_d;
                wp_q   <= wp_d;
                rp_q   <= rp_d;
                gen_q  <= gen_d;
                exp_q  <= exp_d;
                cnt_q  <= cnt_d;
                err_q  <= err_d;
            end
        end

        // Storage needs no reset; validity is tracked by the pointers
        always_ff @(posedge clk_i) begin
            if (enq) mem_q[wp_q[PW-1:0]] <= din & mask_p;
        end

        assign ready_o[i] = rdy;
        assign v_o[i]     = vld;
        assign err_o[i]   = err_q;
        assign data_o[i*data_width_p +: data_width_p]  = dat;
        assign rx_count_o[i*cnt_width_p +: cnt_width_p] = cnt_q;
    end

endmodule

// File: tb/tb_mcl_test_node_array.sv
// Directed bench for mcl_test_node_array: loopback, mask, generate,
// wrap, check/flush, enable hold and mid-stream reset.
module tb_mcl_test_node_array;

    localparam int NC = 4;
    localparam int DW = 4;
    localparam int CW = 8;
    localparam logic [DW-1:0] MASK = 4'h7;

    logic              clk_i = 1'b0;
    logic              reset_i;
    logic [NC-1:0]     en_i;
    logic [2*NC-1:0]   mode_i;
    logic [NC-1:0]     v_i;
    logic [DW*NC-1:0]  data_i;
    logic [NC-1:0]     ready_o;
    logic [NC-1:0]     v_o;
    logic [DW*NC-1:0]  data_o;
    logic [NC-1:0]     yumi_i;
    logic [CW*NC-1:0]  rx_count_o;
    logic [NC-1:0]     err_o;

    int n_vec = 0;
    int n_err = 0;

    mcl_test_node_array #(
        .num_ch_p(NC),
        .data_width_p(DW),
        .fifo_els_p(4),
        .mask_p(MASK),
        .cnt_width_p(CW)
    ) dut (
        .clk_i(clk_i),
        .reset_i(reset_i),
        .en_i(en_i),
        .mode_i(mode_i),
        .v_i(v_i),
        .data_i(data_i),
        .ready_o(ready_o),
        .v_o(v_o),
        .data_o(data_o),
        .yumi_i(yumi_i),
        .rx_count_o(rx_count_o),
        .err_o(err_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [DW-1:0] dq(input int c);
        return data_o[c*DW +: DW];
    endfunction

    function automatic logic [CW-1:0] cq(input int c);
        return rx_count_o[c*CW +: CW];
    endfunction

    logic [DW-1:0] chk_vals [5] = '{4'd0, 4'd1, 4'd2, 4'd7, 4'd4};

    initial begin
        reset_i = 1'b1;
        en_i    = '1;
        mode_i  = '0;
        v_i     = '0;
        data_i  = '0;
        yumi_i  = '0;
        #2;
        chk("rst_ready", ready_o, 0);
        chk("rst_v", v_o, 0);
        chk("rst_data", data_o, 0);
        chk("rst_cnt", rx_count_o, 0);
        chk("rst_err", err_o, 0);
        tick();
        reset_i = 1'b0;
        #1;
        chk("rel_ready", ready_o, 4'hF);

        // loopback fill on ch0
        for (int k = 1; k <= 5; k++) begin
            v_i[0] = 1'b1;
            data_i[0 +: DW] = DW'(k);
            #1;
            chk("lb_ready", ready_o[0], (k <= 4));
            tick();
        end
        for (int j = 0; j < 5; j++) begin
            v_i[0]  = (j <= 1);
            data_i[0 +: DW] = 4'd5;
            yumi_i[0] = 1'b1;
            #1;
            chk("lb_v", v_o[0], 1);
            chk("lb_data", dq(0), j + 1);
            if (j == 0) chk("lb_full_nobypass", ready_o[0], 0);
            tick();
        end
        v_i[0] = 1'b0;
        yumi_i[0] = 1'b0;
        #1;
        chk("lb_empty", v_o[0], 0);
        chk("lb_data0", dq(0), 0);
        chk("lb_cnt", cq(0), 5);

        // mask
        v_i[0] = 1'b1;
        data_i[0 +: DW] = 4'hD;
        tick();
        v_i[0] = 1'b0;
        #1;
        chk("mask_v", v_o[0], 1);
        chk("mask_data", dq(0), 4'hD & MASK);
        yumi_i[0] = 1'b1;
        tick();
        yumi_i[0] = 1'b0;

        // generate on ch3, including wrap
        mode_i[6 +: 2] = 2'b01;
        #1;
        chk("gen_flush_rdy", ready_o[3], 0);
        chk("gen_flush_v", v_o[3], 0);
        tick();
        yumi_i[3] = 1'b1;
        for (int j = 0; j < 18; j++) begin
            #1;
            chk("gen_v", v_o[3], 1);
            chk("gen_data", dq(3), j % 16);
            if (j == 0) chk("gen_other", {v_o[2], ready_o[2]}, 2'b01);
            tick();
        end
        yumi_i[3] = 1'b0;

        // check on ch1
        mode_i[2 +: 2] = 2'b10;
        tick();
        for (int k = 0; k < 5; k++) begin
            v_i[1] = 1'b1;
            data_i[DW +: DW] = chk_vals[k];
            #1;
            chk("chk_v", v_o[1], 0);
            chk("chk_err", err_o[1], (k == 4));
            tick();
        end
        v_i[1] = 1'b0;
        #1;
        chk("chk_err_sticky", err_o[1], 1);
        chk("chk_cnt", cq(1), 5);
        mode_i[2 +: 2] = 2'b11;
        #1;
        chk("snk_flush_rdy", ready_o[1], 0);
        tick();
        chk("snk_err", err_o[1], 0);
        chk("snk_cnt", cq(1), 0);
        chk("snk_rdy", ready_o[1], 1);

        // enable hold on ch2
        for (int k = 1; k <= 3; k++) begin
            v_i[2] = 1'b1;
            data_i[2*DW +: DW] = DW'(k);
            tick();
        end
        v_i[2] = 1'b0;
        en_i[2] = 1'b0;
        yumi_i[2] = 1'b1;
        for (int j = 0; j < 5; j++) begin
            #1;
            chk("en_v", v_o[2], 0);
            chk("en_rdy", ready_o[2], 0);
            tick();
        end
        en_i[2] = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            #1;
            chk("en_drain", dq(2), k);
            tick();
        end
        yumi_i[2] = 1'b0;
        #1;
        chk("en_empty", v_o[2], 0);
        chk("en_cnt", cq(2), 3);

        // mid-stream reset on ch0
        v_i[0] = 1'b1;
        data_i[0 +: DW] = 4'd3;
        tick();
        tick();
        v_i[0] = 1'b0;
        #1;
        chk("pre_rst_v", v_o[0], 1);
        chk("pre_rst_cnt", cq(0), 8);
        reset_i = 1'b1;
        #1;
        chk("mid_rst_v", v_o, 0);
        chk("mid_rst_rdy", ready_o, 0);
        chk("mid_rst_cnt", rx_count_o, 0);
        tick();
        reset_i = 1'b0;
        #1;
        chk("post_rst_rdy", ready_o[0], 1);
        chk("post_rst_v", v_o[0], 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
